pipe_hazard_arbiter: RTL



---
 rtl/pipe_hazard_arbiter_if.sv | 46 ++++
 rtl/pipe_hazard_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_arbiter_if.sv
// Hazard arbiter handshake bundle: level requests in, stall/flush masks and grant info out.
// Latency: pure wiring, no state.
// Backpressure: none; requests are levels that are sampled every cycle.
//
// Signals:
//   req_i         hazard request lines, index 0 = highest priority
//   stall_o       per-stage stall mask
//   flush_o       per-stage flush mask
//   grant_o       one-hot winner
//   grant_vld_o   any request granted
//   grant_id_o    winner index
//   wdog_o        one-cycle watchdog pulse
//   wdog_sticky_o watchdog has fired since reset
//   perf_sel_i    stall counter select
//   perf_cnt_o    selected stall counter
interface pipe_hazard_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int NSTAGE = 6
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_i;
  logic [NSTAGE-1:0] stall_o;
  logic [NSTAGE-1:0] flush_o;
  logic [NREQ-1:0]   grant_o;
  logic              grant_vld_o;
  logic [IDW-1:0]    grant_id_o;
  logic              wdog_o;
  logic              wdog_sticky_o;
  logic [IDW-1:0]    perf_sel_i;
  logic [31:0]       perf_cnt_o;

  // Hazard sources drive requests and read back the masks.
  modport master (
    output req_i, perf_sel_i,
    input  stall_o, flush_o, grant_o, grant_vld_o, grant_id_o,
    input  wdog_o, wdog_sticky_o, perf_cnt_o
  );

  // The arbiter itself.
  modport slave (
    input  req_i, perf_sel_i,
    output stall_o, flush_o, grant_o, grant_vld_o, grant_id_o,
    output wdog_o, wdog_sticky_o, perf_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_arbiter.sv
// Fixed-priority stall/flush arbiter driving per-stage masks from parameter tables.
// Latency: masks and grant are combinational from req_i (0 cycles); state updates at the edge.
// Backpressure: none; a held request keeps its stall mask asserted every cycle it wins.
//
// Ports: clk, rst (synchronous, active-high), ifc (pipe_hazard_arbiter_if.slave).
// Optional per-request grant counters: define PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_arbiter #(
  parameter int                     NSTAGE     = 6,
  parameter int                     NREQ       = 4,
  parameter logic [NREQ*NSTAGE-1:0] STALL_MAP  = {6'b000011, 6'b000010, 6'b000010, 6'b001111},
  parameter logic [NREQ*NSTAGE-1:0] FLUSH_MAP  = {6'b000100, 6'b000110, 6'b001110, 6'b010000},
  parameter logic [NREQ-1:0]        ONESHOT    = 4'b0100,
  parameter logic [NSTAGE-1:0]      RST_FLUSH  = 6'b011111,
  parameter int                     WDOG_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_hazard_arbiter_if.slave  ifc
);

  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_id;
  logic              w_vld;
  logic [NSTAGE-1:0] w_stall;
  logic [NSTAGE-1:0] w_flush;
  logic              w_cnt_cond;
  logic              w_wdog;

  logic [NREQ-1:0]   r_fired;
  logic [IDW-1:0]    r_prev_id;
  logic              r_prev_vld;
  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_wdog_sticky;

  // Winner select and mask lookup. Reset forces no winner and the reset flush mask.
  always_comb begin
    w_vld   = 1'b0;
    w_id    = '0;
    w_grant = '0;
    w_stall = '0;
    w_flush = '0;
    // Scan downward so the lowest asserted index is the last one written.
    for (int r = NREQ - 1; r >= 0; r--) begin
      if (ifc.req_i[r]) begin
        w_vld = 1'b1;
        w_id  = IDW'(r);
      end
    end
    if (rst) begin
      w_vld = 1'b0;
      w_id  = '0;
    end
    if (w_vld) begin
      w_grant[w_id] = 1'b1;
      w_stall       = STALL_MAP[int'(w_id)*NSTAGE +: NSTAGE];
      // A one-shot request that already flushed during this assertion only stalls.
      if (!(ONESHOT[w_id] && r_fired[w_id]))
        w_flush = FLUSH_MAP[int'(w_id)*NSTAGE +: NSTAGE];
    end
    if (rst)
      w_flush = RST_FLUSH;
  end

  // Same winner stalling two cycles in a row extends the streak; a new winner restarts it.
  assign w_cnt_cond = (w_stall != '0) && w_vld && r_prev_vld && (w_id == r_prev_id);
  assign w_wdog     = w_cnt_cond && (r_wdog_cnt == WDOG_W'(WDOG_LIMIT - 1));

  assign ifc.stall_o       = w_stall;
  assign ifc.flush_o       = w_flush;
  assign ifc.grant_o       = w_grant;
  assign ifc.grant_vld_o   = w_vld;
  assign ifc.grant_id_o    = w_id;
  assign ifc.wdog_o        = w_wdog;
  assign ifc.wdog_sticky_o = r_wdog_sticky;

  // One-shot tracking: dropping the request re-arms it, so a request preempted
  // before its first grant still flushes when it finally wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fired <= '0;
    end else begin
      for (int r = 0; r < NREQ; r++) begin
        r_fired[r] <= ifc.req_i[r] &
                      (r_fired[r] | (w_grant[r] & ONESHOT[r] & (|FLUSH_MAP[r*NSTAGE +: NSTAGE])));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_id     <= '0;
      r_prev_vld    <= 1'b0;
      r_wdog_cnt    <= '0;
      r_wdog_sticky <= 1'b0;
    end else begin
      r_prev_id  <= w_id;
      r_prev_vld <= w_vld;
      if (w_stall == '0)
        r_wdog_cnt <= '0;
      else if (w_cnt_cond) begin
        // Saturate at the limit so the pulse cannot repeat during one long stall.
        if (r_wdog_cnt != WDOG_W'(WDOG_LIMIT))
          r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end else
        r_wdog_cnt <= WDOG_W'(1);
      if (w_wdog)
        r_wdog_sticky <= 1'b1;
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_cnt [NREQ];
  logic [31:0] w_perf_cnt;

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREQ; r++) begin
      if (rst)
        r_perf_cnt[r] <= '0;
      else if (w_grant[r])
        r_perf_cnt[r] <= r_perf_cnt[r] + 32'd1;
    end
  end

  always_comb begin
    w_perf_cnt = '0;
    if (int'(ifc.perf_sel_i) < NREQ)
      w_perf_cnt = r_perf_cnt[ifc.perf_sel_i];
  end

  assign ifc.perf_cnt_o = w_perf_cnt;
`else
  logic w_unused_perf_sel;
  assign w_unused_perf_sel = ^ifc.perf_sel_i;
  assign ifc.perf_cnt_o    = '0;
`endif

endmodule
